seg7_ascii_scan: RTL and testbench



---
 rtl/seg7_ascii_scan.sv | 119 +++++++++++
 tb/tb_seg7_ascii_scan.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_ascii_scan.sv
// seg7_ascii_scan: scans 8 ASCII characters onto a multiplexed 7-segment display.
// The 8 bytes are snapshotted at each frame start, so a frame never mixes old and new text.
// One digit is lit per prescaler slot. Outputs are registered and are driven
// active-low when SEG_ACTIVE_LOW=1.
module seg7_ascii_scan #(
   parameter int SCAN_DIV       = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] display_data,
   input  logic        en,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PW-1:0] presc;
   logic [2:0]    digit_idx;
   logic          load_pend;
   logic [63:0]   snap;
   logic          tick;
   logic          frame_start;
   logic [7:0]    cur_byte;
   logic [7:0]    ch;
   logic [6:0]    seg_hi;
   logic [7:0]    an_hi;

   // tick is gated by en so a frozen scan can never start a frame or advance a slot
   assign tick        = en && (presc == PW'(SCAN_DIV - 1));
   assign frame_start = (tick && digit_idx == 3'd7) || (load_pend && en);
   assign cur_byte    = snap[{digit_idx, 3'b000} +: 8];
   // slot 0 is the leftmost digit, so the first UART character reads first
   assign an_hi       = 8'h80 >> digit_idx;

   // prescaler and digit slot counter; both hold while en is low
   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         digit_idx <= 3'd0;
      end else if (en) begin
         if (tick) begin
            presc     <= '0;
            digit_idx <= digit_idx + 3'd1;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   // frame snapshot; load_pend forces a load on the first enabled cycle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         snap      <= {8{8'h20}};
         load_pend <= 1'b1;
      end else if (frame_start) begin
         snap      <= display_data;
         load_pend <= 1'b0;
      end
   end

   // ASCII to active-high gfedcba; letters fold to upper case, anything unknown shows a+d
   always_comb begin
      ch = cur_byte;
      if (ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
      case (ch)
         8'h30: seg_hi = 7'h3F;
         8'h31: seg_hi = 7'h06;
         8'h32: seg_hi = 7'h5B;
         8'h33: seg_hi = 7'h4F;
         8'h34: seg_hi = 7'h66;
         8'h35: seg_hi = 7'h6D;
         8'h36: seg_hi = 7'h7D;
         8'h37: seg_hi = 7'h07;
         8'h38: seg_hi = 7'h7F;
         8'h39: seg_hi = 7'h6F;
         8'h41: seg_hi = 7'h77;
         8'h42: seg_hi = 7'h7C;
         8'h43: seg_hi = 7'h39;
         8'h44: seg_hi = 7'h5E;
         8'h45: seg_hi = 7'h79;
         8'h46: seg_hi = 7'h71;
         8'h47: seg_hi = 7'h3D;
         8'h48: seg_hi = 7'h76;
         8'h49: seg_hi = 7'h06;
         8'h4A: seg_hi = 7'h1E;
         8'h4C: seg_hi = 7'h38;
         8'h4E: seg_hi = 7'h54;
         8'h4F: seg_hi = 7'h5C;
         8'h50: seg_hi = 7'h73;
         8'h51: seg_hi = 7'h67;
         8'h52: seg_hi = 7'h50;
         8'h53: seg_hi = 7'h6D;
         8'h54: seg_hi = 7'h78;
         8'h55: seg_hi = 7'h3E;
         8'h59: seg_hi = 7'h6E;
         8'h2D: seg_hi = 7'h40;
         8'h5F: seg_hi = 7'h08;
         8'h20: seg_hi = 7'h00;
         default: seg_hi = 7'h09;
      endcase
   end

   // registered outputs with polarity applied; en low blanks on the next edge
   always_ff @(posedge clk) begin
      if (rst) begin
         an  <= {8{SEG_ACTIVE_LOW}};
         seg <= {7{SEG_ACTIVE_LOW}};
         dp  <= SEG_ACTIVE_LOW;
      end else begin
         an  <= (en ? an_hi  : 8'h00) ^ {8{SEG_ACTIVE_LOW}};
         seg <= (en ? seg_hi : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
         dp  <= SEG_ACTIVE_LOW;
      end
   end

endmodule

// File: tb/tb_seg7_ascii_scan.sv
// Bench for seg7_ascii_scan: two instances (SCAN_DIV=4 active-low, SCAN_DIV=2 active-high)
// share stimulus. A frame-level model counts enabled cycles since reset and checks every cycle.
module tb_seg7_ascii_scan;

   localparam int DIV_A = 4;
   localparam int DIV_B = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [63:0] data;
   logic [7:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_ascii_scan #(.SCAN_DIV(DIV_A), .SEG_ACTIVE_LOW(1'b1)) dut_a (
      .clk(clk), .rst(rst), .display_data(data), .en(en),
      .an(an_a), .seg(seg_a), .dp(dp_a));

   seg7_ascii_scan #(.SCAN_DIV(DIV_B), .SEG_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst), .display_data(data), .en(en),
      .an(an_b), .seg(seg_b), .dp(dp_b));

   always #5 clk = ~clk;

   // character table: position j of keys maps to codes[j]
   logic [6:0] codes [33] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
      7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h06, 7'h1E,
      7'h38, 7'h54, 7'h5C, 7'h73, 7'h67, 7'h50, 7'h6D, 7'h78, 7'h3E, 7'h6E,
      7'h40, 7'h08, 7'h00};

   function automatic logic [6:0] dec(input logic [7:0] b);
      string      keys;
      logic [7:0] u;
      keys = "0123456789ABCDEFGHIJLNOPQRSTUY-_ ";
      u = b;
      if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
      for (int j = 0; j < 33; j++)
         if (keys[j] == u) return codes[j];
      return 7'h09;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // model: slot = (enabled cycles / div) % 8; load on first enabled cycle or last cycle of a frame
   int          en_cnt [2];
   logic [63:0] snap_m [2];
   logic [7:0]  exp_an [2];
   logic [6:0]  exp_seg [2];
   logic        exp_dp [2];
   bit          armed = 0;

   initial forever begin
      @(negedge clk);
      if (armed) begin
         check("a.an", an_a, exp_an[0]);
         check("a.seg", {1'b0, seg_a}, {1'b0, exp_seg[0]});
         check("a.dp", {7'b0, dp_a}, {7'b0, exp_dp[0]});
         check("b.an", an_b, exp_an[1]);
         check("b.seg", {1'b0, seg_b}, {1'b0, exp_seg[1]});
         check("b.dp", {7'b0, dp_b}, {7'b0, exp_dp[1]});
      end
      for (int i = 0; i < 2; i++) begin
         int         d;
         int         slot;
         logic [7:0] a;
         logic [6:0] s;
         d = (i == 0) ? DIV_A : DIV_B;
         a = 8'h00;
         s = 7'h00;
         if (rst) begin
            en_cnt[i] = 0;
            snap_m[i] = {8{8'h20}};
         end else if (en) begin
            slot = (en_cnt[i] / d) % 8;
            a = 8'h80 >> slot;
            s = dec(snap_m[i][slot*8 +: 8]);
            if (en_cnt[i] == 0 || (en_cnt[i] % (8*d)) == 8*d - 1) snap_m[i] = data;
            en_cnt[i]++;
         end
         exp_an[i]  = (i == 0) ? ~a : a;
         exp_seg[i] = (i == 0) ? ~s : s;
         exp_dp[i]  = (i == 0);
      end
      if (rst) armed = 1;
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] rnd_byte();
      string pool;
      pool = "0123456789AbCdEfGhIjLnOpQrStUy-_ kMzW";
      if ($urandom_range(0, 4) == 0) return 8'($urandom);
      return pool[$urandom_range(0, 36)];
   endfunction

   logic [6:0] sweep [7] = '{7'h7F, 7'h00, 7'h40, 7'h77, 7'h09, 7'h09, 7'h09};
   logic [7:0] one_hot;

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      data = 64'h3736353433323130;
      cyc(3);
      check("rst a.an", an_a, 8'hFF);
      check("rst a.seg", {1'b0, seg_a}, 8'h7F);
      check("rst a.dp", {7'b0, dp_a}, 8'h01);
      check("rst b.an", an_b, 8'h00);
      check("rst b.seg", {1'b0, seg_b}, 8'h00);
      check("rst b.dp", {7'b0, dp_b}, 8'h00);
      rst = 1'b0;
      en  = 1'b1;
      cyc(2);
      check("slot0 a.an", an_a, 8'h7F);
      check("slot0 a.seg", {1'b0, seg_a}, 8'h40);
      check("slot0 b.an", an_b, 8'h80);
      check("slot0 b.seg", {1'b0, seg_b}, 8'h3F);
      cyc(3);
      check("slot1 a.an", an_a, 8'hBF);
      check("slot1 a.seg", {1'b0, seg_a}, 8'h79);
      cyc(24);
      check("slot7 a.an", an_a, 8'hFE);
      check("slot7 a.seg", {1'b0, seg_a}, 8'h78);
      cyc(4);
      check("wrap a.an", an_a, 8'h7F);
      // change text while slot 3 is showing
      cyc(13);
      data = {8{8'h41}};
      cyc(6);
      check("mid slot4 a.an", an_a, 8'hF7);
      check("mid slot4 a.seg", {1'b0, seg_a}, 8'h19);
      cyc(16);
      check("next frame a.an", an_a, 8'h7F);
      check("next frame a.seg", {1'b0, seg_a}, 8'h08);
      // drop en during slot 5
      cyc(18);
      en = 1'b0;
      cyc(1);
      check("en0 a.an", an_a, 8'hFF);
      check("en0 a.seg", {1'b0, seg_a}, 8'h7F);
      cyc(9);
      en = 1'b1;
      cyc(1);
      check("resume a.an", an_a, 8'hFB);
      cyc(2);
      check("slot6 a.an", an_a, 8'hFD);
      // reset in slot 6
      rst = 1'b1;
      cyc(1);
      check("midrst a.an", an_a, 8'hFF);
      rst = 1'b0;
      cyc(1);
      check("postrst a.an", an_a, 8'h7F);
      check("postrst a.seg", {1'b0, seg_a}, 8'h7F);
      cyc(1);
      check("reload a.seg", {1'b0, seg_a}, 8'h08);
      // decode sweep on the SCAN_DIV=2 active-high instance
      rst  = 1'b1;
      data = 64'h413F807A612D2038;
      cyc(1);
      rst = 1'b0;
      for (int k = 0; k < 7; k++) begin
         cyc(2);
         one_hot = 8'h80 >> k;
         check("sweep b.an", an_b, one_hot);
         check("sweep b.seg", {1'b0, seg_b}, {1'b0, sweep[k]});
      end
      // randomized phase, checked by the model every cycle
      repeat (3000) begin
         cyc(1);
         if ($urandom_range(0, 19) == 0)
            for (int k = 0; k < 8; k++) data[k*8 +: 8] = rnd_byte();
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 199) == 0);
      end
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
